// File: rtl/write_back_unit.sv
// write_back_unit
//   Final stage of the integer pipeline. It selects the value to be written
//   to the register file and, for loads, formats the raw memory word. It
//   then registers the value, the destination index and the write enable.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst_n        : asynchronous active-low reset (registered outputs only)
//   wb_sel       : source select 00 ALU, 01 immediate, 10 load, 11 PC+4
//   alu_result   : ALU output
//   immediate    : decoded immediate (LUI path)
//   mem_data     : raw aligned load word from data memory
//   pc_next      : return address for JAL/JALR
//   load_funct3  : load type (LB/LH/LW/LBU/LHU)
//   load_addr_lo : byte offset of the load address
//   rd_addr_i    : destination register index
//   reg_we_i     : register write request
//   stall        : hold registered outputs
//   flush        : squash registered outputs (wins over stall)
//   write_data   : combinational selected write-back value
//   wb_data      : registered write_data
//   wb_rd_addr   : registered destination index
//   wb_we        : registered write enable, never set for x0
module write_back_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc_next,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      load_addr_lo,
    input  logic [4:0]      rd_addr_i,
    input  logic            reg_we_i,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_we
);

    localparam logic [1:0] REG_WB_ALU_OUT = 2'b00;
    localparam logic [1:0] REG_WB_IMM_DAT = 2'b01;
    localparam logic [1:0] REG_WB_MEM_DAT = 2'b10;
    localparam logic [1:0] REG_WB_PC_NEXT = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Extracts the addressed byte or halfword and sign- or zero-extends it.
    // LW and any unlisted funct3 pass the word through untouched.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] word,
        input logic [2:0]      funct3,
        input logic [1:0]      lo
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = word[lo*8 +: 8];
        // Only bit 1 of the offset picks the halfword; bit 0 is ignored.
        half_sel = lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   format_load = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  format_load = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   format_load = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  format_load = {{(XLEN-16){1'b0}}, half_sel};
            default: format_load = word;
        endcase
    endfunction

    logic [XLEN-1:0] wb_data_p1;
    logic [4:0]      wb_rd_addr_p1;
    logic            vld_p1;

    // Stage 0: combinational source select, independent of clock and reset.
    always_comb begin
        write_data = alu_result;
        case (wb_sel)
            REG_WB_ALU_OUT: write_data = alu_result;
            REG_WB_IMM_DAT: write_data = immediate;
            REG_WB_MEM_DAT: write_data = format_load(mem_data, load_funct3, load_addr_lo);
            REG_WB_PC_NEXT: write_data = pc_next;
            default:        write_data = alu_result;
        endcase
    end

    // Stage 0 -> 1: register the write-back; flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_p1    <= '0;
            wb_rd_addr_p1 <= '0;
            vld_p1        <= 1'b0;
        end else if (flush) begin
            wb_data_p1    <= '0;
            wb_rd_addr_p1 <= '0;
            vld_p1        <= 1'b0;
        end else if (!stall) begin
            wb_data_p1    <= write_data;
            wb_rd_addr_p1 <= rd_addr_i;
            // x0 is hardwired to zero, so a write to it is dropped here.
            vld_p1        <= reg_we_i && (rd_addr_i != 5'd0);
        end
    end

    assign wb_data    = wb_data_p1;
    assign wb_rd_addr = wb_rd_addr_p1;
    assign wb_we      = vld_p1;

endmodule

// File: tb/tb_write_back_unit.sv
module tb_write_back_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] immediate;
    logic [31:0] mem_data;
    logic [31:0] pc_next;
    logic [2:0]  load_funct3;
    logic [1:0]  load_addr_lo;
    logic [4:0]  rd_addr_i;
    logic        reg_we_i;
    logic        stall;
    logic        flush;
    logic [31:0] write_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_we;

    int n_pass  = 0;
    int n_total = 0;

    write_back_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_sel       (wb_sel),
        .alu_result   (alu_result),
        .immediate    (immediate),
        .mem_data     (mem_data),
        .pc_next      (pc_next),
        .load_funct3  (load_funct3),
        .load_addr_lo (load_addr_lo),
        .rd_addr_i    (rd_addr_i),
        .reg_we_i     (reg_we_i),
        .stall        (stall),
        .flush        (flush),
        .write_data   (write_data),
        .wb_data      (wb_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_we        (wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_regs(input string tag, input logic [31:0] d,
                              input logic [4:0] rd, input logic we);
        check({tag, "_data"}, wb_data, d);
        check({tag, "_rd"},   {27'd0, wb_rd_addr}, {27'd0, rd});
        check({tag, "_we"},   {31'd0, wb_we}, {31'd0, we});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        wb_sel       = 2'b00;
        alu_result   = 32'hA5A5_A5A5;
        immediate    = 32'h1234_5678;
        mem_data     = 32'hBBBB_BBBB;
        pc_next      = 32'h0000_1000;
        load_funct3  = 3'b010;
        load_addr_lo = 2'd0;
        rd_addr_i    = 5'd5;
        reg_we_i     = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;

        // Reset state, write_data live during reset
        #2;
        check_regs("reset", 32'h0, 5'd0, 1'b0);
        check("wd_in_reset", write_data, 32'hA5A5_A5A5);
        tick();
        check_regs("reset_held", 32'h0, 5'd0, 1'b0);

        // Release reset between edges; first capture on next edge
        #2 rst_n = 1'b1;
        #1;
        check_regs("post_release", 32'h0, 5'd0, 1'b0);
        tick();
        check_regs("alu_capture", 32'hA5A5_A5A5, 5'd5, 1'b1);

        // Source select
        wb_sel = 2'b01;
        #0 check("sel_imm", write_data, 32'h1234_5678);
        #1;
        check("sel_imm", write_data, 32'h1234_5678);
        wb_sel = 2'b11;
        #1;
        check("sel_pc", write_data, 32'h0000_1000);

        // Load formatting
        wb_sel = 2'b10;
        load_funct3 = 3'b010; load_addr_lo = 2'd3; #1;
        check("lw", write_data, 32'hBBBB_BBBB);
        load_funct3 = 3'b000; #1;
        check("lb_3", write_data, 32'hFFFF_FFBB);
        load_funct3 = 3'b100; #1;
        check("lbu_3", write_data, 32'h0000_00BB);
        mem_data = 32'h0000_8001; load_funct3 = 3'b001; load_addr_lo = 2'd0; #1;
        check("lh_0", write_data, 32'hFFFF_8001);
        load_funct3 = 3'b101; #1;
        check("lhu_0", write_data, 32'h0000_8001);
        load_funct3 = 3'b001; load_addr_lo = 2'd3; #1;
        check("lh_3", write_data, 32'h0000_0000);
        load_funct3 = 3'b000; load_addr_lo = 2'd1; #1;
        check("lb_1", write_data, 32'hFFFF_FF80);

        // x0 write suppression
        rd_addr_i = 5'd0; reg_we_i = 1'b1;
        tick();
        check_regs("x0", 32'hFFFF_FF80, 5'd0, 1'b0);
        wb_sel = 2'b01; rd_addr_i = 5'd5;
        tick();
        check_regs("rd5", 32'h1234_5678, 5'd5, 1'b1);

        // Stall holds across two edges with changing inputs
        stall = 1'b1; wb_sel = 2'b00; alu_result = 32'h1111_1111; rd_addr_i = 5'd9;
        tick();
        check_regs("stall1", 32'h1234_5678, 5'd5, 1'b1);
        alu_result = 32'h2222_2222; rd_addr_i = 5'd10; reg_we_i = 1'b0;
        tick();
        check_regs("stall2", 32'h1234_5678, 5'd5, 1'b1);

        // Flush beats stall
        flush = 1'b1;
        tick();
        check_regs("flush", 32'h0, 5'd0, 1'b0);
        flush = 1'b0; stall = 1'b0;

        // Capture, then asynchronous reset between edges
        alu_result = 32'hCAFE_BABE; rd_addr_i = 5'd7; reg_we_i = 1'b1;
        tick();
        check_regs("cap7", 32'hCAFE_BABE, 5'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_regs("async_rst", 32'h0, 5'd0, 1'b0);
        wb_sel = 2'b11; #1;
        check("wd_rst_pc", write_data, 32'h0000_1000);
        tick();
        check_regs("rst_held", 32'h0, 5'd0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check_regs("recapture", 32'h0000_1000, 5'd7, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
